seg_decode_in: RTL
==================

// Module: seg_decode_in
// PURPOSE
//  Inverse of the display encoder: samples two active-low 7-segment digit buses plus a sign line,
//  waits until the pattern is stable, and converts it back to a binary value 0..99 with a sign.
//  Sits on the remote-control input side; consumer reads the value via a valid/ack handshake.
//  Segment order on each bus is {a,b,c,d,e,f,g}, bit 6 = a, segment lit = 0.
// PARAMETERS
//  SYNC_STAGES    2  flop stages on the 15-bit input word {sinal_in,seg_d,seg_u}; legal range 1..4
//  STABLE_CYCLES  4  consecutive equal synchronized samples needed before accepting; legal range 1..255
// PORTS
//  clk       in   1  single clock, all logic on the rising edge
//  rst       in   1  asynchronous, active-high reset
//  seg_u     in   7  units digit segments, active-low {a..g}
//  seg_d     in   7  tens digit segments, active-low {a..g}
//  sinal_in  in   1  sign of the displayed number
//  n         out  8  decoded value tens*10+units, 0..99; bit 7 is always 0
//  sinal     out  1  captured sign
//  valid     out  1  result available; held until acknowledged
//  ack       in   1  consumer acknowledge; only meaningful while valid=1
//  err       out  1  at least one digit pattern was not a legal digit
// BEHAVIOUR
//  - Reset (async, rst=1): n=0, sinal=0, valid=0, err=0, cnt=0, sync flops=0, first-word flag cleared, FSM=SCAN.
//  - Digit table (active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100; every other pattern is illegal.
//  - w_s = word after SYNC_STAGES flops; w_prev = w_s from the previous cycle.
//    Each edge: cnt <= (w_s==w_prev) ? min(cnt+1, STABLE_CYCLES-1) : 0; w_prev <= w_s.
//  - Accept: FSM=SCAN, w_s==w_prev, cnt==STABLE_CYCLES-1, and (no word accepted since reset
//    or w_s != w_last). On accept: w_last<=w_s; n, sinal, err registered; valid<=1; FSM->HOLD.
//  - Latency: input change to valid=1 is SYNC_STAGES+STABLE_CYCLES+1 rising edges (7 with defaults).
//  - n = tens*10+units computed in 8 bits; if err=1 then n=0. sinal always reflects the captured sign.
//  - HOLD: n/sinal/err/valid frozen; ack=1 at a rising edge -> valid=0, FSM->SCAN next cycle.
//    ack while valid=0 is ignored. cnt and w_prev keep running during HOLD.
//  - Word changed and restabilized during HOLD: accepted on the first SCAN cycle where the accept
//    condition holds (cnt saturates, so this can be the cycle right after ack).
//  - Same word as w_last never re-reported; a glitch shorter than STABLE_CYCLES+1 samples resets cnt, no report.
//  - Reset mid-count or mid-HOLD: everything cleared immediately; the held input is reported again after full latency.
// CONFIGURATION
//  DECODE_BLANK_EN defined: tens bus all-off (1111111) decodes as 0 (leading-zero blanking), err=0.
//  DECODE_BLANK_EN undefined: all-off on either bus is illegal -> err=1, n=0.
//  Units bus all-off is illegal in both builds.
// TESTING (defaults SYNC_STAGES=2, STABLE_CYCLES=4)
//  1 rst=1 at any time -> n=0, sinal=0, valid=0, err=0 asynchronously; no valid for 7 edges after release with inputs at 0.
//  2 seg_d=0010010, seg_u=0000100, sinal_in=1 held -> valid=1 after 7th edge, n=8'd29, sinal=1, err=0;
//    no ack for 20 cycles -> all frozen; ack one cycle -> valid=0 next cycle, never reasserted for same word.
//  3 seg_u toggled 0000100->1001111 for 2 cycles then back -> no valid; held as 1001111 -> valid, n=8'd21.
//  4 seg_u=1111110 held -> valid=1, err=1, n=0.
//  5 seg_d=1111111, seg_u=0100100: with DECODE_BLANK_EN -> n=8'd5, err=0; without -> n=0, err=1.
//  6 rst pulse at cycle 4 of stabilization and again during HOLD -> outputs cleared; word re-reported 7 edges after release.

Source files
------------

// File: rtl/seg_decode_in_if.sv
// Bundles the segment-decoder input buses and the valid/ack result port.
// The master side drives the segment buses and ack; the slave side is the decoder.
interface seg_decode_in_if;
  logic [6:0] seg_u;
  logic [6:0] seg_d;
  logic       sinal_in;
  logic [7:0] n;
  logic       sinal;
  logic       valid;
  logic       ack;
  logic       err;

  modport master (
    output seg_u, seg_d, sinal_in, ack,
    input  n, sinal, valid, err
  );

  modport slave (
    input  seg_u, seg_d, sinal_in, ack,
    output n, sinal, valid, err
  );
endinterface

// File: rtl/seg_decode_in.sv
// Turns two debounced active-low 7-segment digits plus a sign back into a signed 0..99 value.
// The valid/ack result is held until ack. Optional macro DECODE_BLANK_EN: an all-off tens digit decodes as 0.
module seg_decode_in #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  seg_decode_in_if.slave bus
);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic {SCAN, HOLD} state_t;

  logic [SYNC_STAGES-1:0][14:0] sync_q;
  logic [SYNC_STAGES:0]         fill_q;
  logic [14:0] w_s;
  logic [14:0] w_prev;
  logic [14:0] w_last;
  logic        have_last;
  logic [7:0]  cnt;
  state_t      state;
  logic [7:0]  n_q;
  logic        sinal_q;
  logic        valid_q;
  logic        err_q;

  logic        same;
  logic [4:0]  dec_u;
  logic [4:0]  dec_d;
  logic        bad;
  logic [7:0]  value;

  // Returns {legal, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'd0};
      7'b1001111: decode = {1'b1, 4'd1};
      7'b0010010: decode = {1'b1, 4'd2};
      7'b0000110: decode = {1'b1, 4'd3};
      7'b1001100: decode = {1'b1, 4'd4};
      7'b0100100: decode = {1'b1, 4'd5};
      7'b0100000: decode = {1'b1, 4'd6};
      7'b0001111: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0000100: decode = {1'b1, 4'd9};
      default:    decode = 5'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= {bus.sinal_in, bus.seg_d, bus.seg_u};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_s = sync_q[SYNC_STAGES-1];
  // The reset contents of the sync chain and w_prev are not real samples, so they never count
  // as stable; this is what makes a held word take the full latency after reset.
  assign same = (w_s == w_prev) && fill_q[SYNC_STAGES];

  assign dec_u = decode(w_s[6:0]);
`ifdef DECODE_BLANK_EN
  assign dec_d = (w_s[13:7] == 7'b1111111) ? {1'b1, 4'd0} : decode(w_s[13:7]);
`else
  assign dec_d = decode(w_s[13:7]);
`endif
  assign bad   = !(dec_u[4] && dec_d[4]);
  assign value = {4'd0, dec_d[3:0]} * 8'd10 + {4'd0, dec_u[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_prev    <= '0;
      w_last    <= '0;
      have_last <= 1'b0;
      cnt       <= '0;
      state     <= SCAN;
      n_q       <= '0;
      sinal_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      w_prev <= w_s;
      if (!same)               cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      case (state)
        SCAN: begin
          if (same && cnt == CNT_MAX && (!have_last || w_s != w_last)) begin
            w_last    <= w_s;
            have_last <= 1'b1;
            n_q       <= bad ? 8'd0 : value;
            sinal_q   <= w_s[14];
            err_q     <= bad;
            valid_q   <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            state   <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.n     = n_q;
  assign bus.sinal = sinal_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule
